// File: rtl/cpu_pkg.sv
// Shared core types for the ALU reservation station: opcodes, entry/issue
// records and the result-bus snoop helper.
package cpu_pkg;

  localparam int ROB_ID_W = 3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic                busy;
    logic [ROB_ID_W-1:0] tag;
    logic [31:0]         val;
  } src_t;

  typedef struct packed {
    logic                valid;
    logic [ROB_ID_W-1:0] id;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         imm;
    logic [5:0]          shamt;
    logic [31:0]         pc;
    src_t                src1;
    src_t                src2;
  } rs_entry_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [5:0]  shamt;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } issue_t;

  typedef struct packed {
    logic                valid;
    logic [ROB_ID_W-1:0] id;
    logic [31:0]         val;
  } cdb_t;

  // A pending source picks up a matching broadcast; the ALU bus wins a tie.
  function automatic src_t snoop(src_t s, cdb_t alu, cdb_t lsb);
    src_t r;
    r = s;
    if (s.busy) begin
      if (alu.valid && alu.id == s.tag) begin
        r.busy = 1'b0;
        r.val  = alu.val;
      end else if (lsb.valid && lsb.id == s.tag) begin
        r.busy = 1'b0;
        r.val  = lsb.val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, result-bus and issue signals of the ALU reservation station.
interface alu_rs_if #(
  parameter int ROB_ID_W = cpu_pkg::ROB_ID_W
);
  logic                disp_valid;
  logic                disp_ready;
  logic [ROB_ID_W-1:0] disp_id;
  logic [6:0]          disp_opcode;
  logic [2:0]          disp_funct3;
  logic [6:0]          disp_funct7;
  logic [31:0]         disp_imm;
  logic [5:0]          disp_shamt;
  logic [31:0]         disp_pc;
  logic                disp_rs1_busy;
  logic [ROB_ID_W-1:0] disp_rs1_tag;
  logic [31:0]         disp_rs1_val;
  logic                disp_rs2_busy;
  logic [ROB_ID_W-1:0] disp_rs2_tag;
  logic [31:0]         disp_rs2_val;

  logic                alu_cdb_valid;
  logic [ROB_ID_W-1:0] alu_cdb_id;
  logic [31:0]         alu_cdb_val;
  logic                lsb_cdb_valid;
  logic [ROB_ID_W-1:0] lsb_cdb_id;
  logic [31:0]         lsb_cdb_val;

  logic                have_ins;
  logic [ROB_ID_W-1:0] ins_id;
  logic [31:0]         rs1_val;
  logic [31:0]         rs2_val;
  logic [31:0]         imm_val;
  logic [5:0]          shamt_val;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [31:0]         request_PC;

  modport slave (
    input  disp_valid, disp_id, disp_opcode, disp_funct3, disp_funct7, disp_imm,
           disp_shamt, disp_pc, disp_rs1_busy, disp_rs1_tag, disp_rs1_val,
           disp_rs2_busy, disp_rs2_tag, disp_rs2_val,
           alu_cdb_valid, alu_cdb_id, alu_cdb_val,
           lsb_cdb_valid, lsb_cdb_id, lsb_cdb_val,
    output disp_ready, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val,
           opcode, funct3, funct7, request_PC
  );

  modport master (
    output disp_valid, disp_id, disp_opcode, disp_funct3, disp_funct7, disp_imm,
           disp_shamt, disp_pc, disp_rs1_busy, disp_rs1_tag, disp_rs1_val,
           disp_rs2_busy, disp_rs2_tag, disp_rs2_val,
           alu_cdb_valid, alu_cdb_id, alu_cdb_val,
           lsb_cdb_valid, lsb_cdb_id, lsb_cdb_val,
    input  disp_ready, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val,
           opcode, funct3, funct7, request_PC
  );
endinterface

// File: rtl/alu_rs_age_select.sv
// Age-matrix oldest-ready picker: older_q[i][j] set means entry i is older
// than entry j; a requester wins when no other requester is older than it.
module age_select #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         alloc_i,
  input  logic [N-1:0] alloc_oh_i,
  input  logic [N-1:0] valid_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o,
  output logic         found_o
);

  logic [N-1:0] older_q [N];
  logic [N-1:0] older_d [N];

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = req_i[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req_i[j] && older_q[j][i]) grant_o[i] = 1'b0;
      end
    end
  end

  assign found_o = |grant_o;

  // A new entry is younger than everything currently live.
  always_comb begin
    older_d = older_q;
    if (alloc_i) begin
      for (int k = 0; k < N; k++) begin
        if (alloc_oh_i[k]) begin
          older_d[k] = '0;
          for (int i = 0; i < N; i++) begin
            if (valid_i[i]) older_d[i][k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, snoops both result buses and
// issues the oldest fully-ready op to the ALU through registered outputs.
module alu_rs
  import cpu_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  parameter int ROB_ID_W  = cpu_pkg::ROB_ID_W  // entries use the cpu_pkg width
) (
  input  logic    clk_in,
  input  logic    rst_n_in,
  input  logic    rdy_in,
  input  logic    flush_pipline,
  alu_rs_if.slave bus
);

  rs_entry_t entries_q [N_ENTRIES];
  rs_entry_t entries_d [N_ENTRIES];
  rs_entry_t new_entry;

  logic [N_ENTRIES-1:0] valid_vec, ready_vec, free_oh, grant;
  logic                 found, live, accept, have_d, have_q;
  logic [ROB_ID_W-1:0]  ins_id_d, ins_id_q;
  issue_t               iss_d, iss_q;
  cdb_t                 alu_cdb, lsb_cdb;

  assign alu_cdb = '{valid: bus.alu_cdb_valid, id: bus.alu_cdb_id, val: bus.alu_cdb_val};
  assign lsb_cdb = '{valid: bus.lsb_cdb_valid, id: bus.lsb_cdb_id, val: bus.lsb_cdb_val};

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      ready_vec[i] = entries_q[i].valid && !entries_q[i].src1.busy && !entries_q[i].src2.busy;
    end
  end

  // Lowest free slot wins; a slot freed by this cycle's issue is not yet free.
  always_comb begin
    free_oh = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  assign bus.disp_ready = ~&valid_vec;
  assign live           = rdy_in && !flush_pipline;
  assign accept         = live && bus.disp_valid && bus.disp_ready;
  assign have_d         = live && found;

  age_select #(.N(N_ENTRIES)) u_age (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .alloc_i    (accept),
    .alloc_oh_i (free_oh),
    .valid_i    (valid_vec),
    .req_i      (ready_vec),
    .grant_o    (grant),
    .found_o    (found)
  );

  always_comb begin
    new_entry.valid  = 1'b1;
    new_entry.id     = bus.disp_id;
    new_entry.opcode = bus.disp_opcode;
    new_entry.funct3 = bus.disp_funct3;
    new_entry.funct7 = bus.disp_funct7;
    new_entry.imm    = bus.disp_imm;
    new_entry.shamt  = bus.disp_shamt;
    new_entry.pc     = bus.disp_pc;
    new_entry.src1   = snoop('{busy: bus.disp_rs1_busy, tag: bus.disp_rs1_tag,
                               val: bus.disp_rs1_val}, alu_cdb, lsb_cdb);
    new_entry.src2   = snoop('{busy: bus.disp_rs2_busy, tag: bus.disp_rs2_tag,
                               val: bus.disp_rs2_val}, alu_cdb, lsb_cdb);
  end

  always_comb begin
    entries_d = entries_q;
    if (rdy_in) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (flush_pipline) begin
          entries_d[i].valid = 1'b0;
        end else begin
          if (entries_q[i].valid) begin
            entries_d[i].src1 = snoop(entries_q[i].src1, alu_cdb, lsb_cdb);
            entries_d[i].src2 = snoop(entries_q[i].src2, alu_cdb, lsb_cdb);
          end
          if (grant[i]) entries_d[i].valid = 1'b0;
          if (accept && free_oh[i]) entries_d[i] = new_entry;
        end
      end
    end
  end

  // Issue outputs keep their last values when nothing is selected.
  always_comb begin
    iss_d    = iss_q;
    ins_id_d = ins_id_q;
    if (have_d) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (grant[i]) begin
          ins_id_d     = entries_q[i].id;
          iss_d.opcode = entries_q[i].opcode;
          iss_d.funct3 = entries_q[i].funct3;
          iss_d.funct7 = entries_q[i].funct7;
          iss_d.imm    = entries_q[i].imm;
          iss_d.shamt  = entries_q[i].shamt;
          iss_d.pc     = entries_q[i].pc;
          iss_d.rs1    = entries_q[i].src1.val;
          iss_d.rs2    = entries_q[i].src2.val;
        end
      end
    end
  end

  // NOTE: only the valid bits need a reset; payload is never read while its
  // entry is invalid, so the entry storage stays reset-free.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_ENTRIES; i++) entries_q[i].valid <= 1'b0;
    end else begin
      entries_q <= entries_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      have_q   <= 1'b0;
      ins_id_q <= '0;
      iss_q    <= '0;
    end else begin
      have_q   <= have_d;
      ins_id_q <= ins_id_d;
      iss_q    <= iss_d;
    end
  end

  assign bus.have_ins   = have_q;
  assign bus.ins_id     = ins_id_q;
  assign bus.rs1_val    = iss_q.rs1;
  assign bus.rs2_val    = iss_q.rs2;
  assign bus.imm_val    = iss_q.imm;
  assign bus.shamt_val  = iss_q.shamt;
  assign bus.opcode     = iss_q.opcode;
  assign bus.funct3     = iss_q.funct3;
  assign bus.funct7     = iss_q.funct7;
  assign bus.request_PC = iss_q.pc;

endmodule
